// File: rtl/riscv_constants.sv
// Shared memory-stage types for the RV32I core: memory op codes, load/store funct3
// encodings and the LSU state type.
package riscv_constants;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } lsu_state_t;

  // Illegal widths share the misaligned path so both retire without touching memory.
  function automatic logic access_fault(input mem_op_t op, input logic [2:0] funct3,
                                        input logic [1:0] off);
    logic legal;
    legal = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: legal = 1'b1;
      F3_LH, F3_LHU: legal = (off[0] == 1'b0);
      F3_LW:         legal = (off == 2'b00);
      default:       legal = 1'b0;
    endcase
    if (op == MEM_STORE && funct3[2]) legal = 1'b0;
    return !legal;
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Memory-side bus between the LSU (master) and its synchronous single-port BRAM (slave).
interface riscv_lsu_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  mem_en_out;
  logic [3:0]            mem_we_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [31:0]           mem_wdata_out;
  logic [31:0]           mem_rdata_in;

  modport master (
    output mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  mem_rdata_in
  );

  modport slave (
    input  mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output mem_rdata_in
  );
endinterface

// File: rtl/riscv_load_align.sv
// Selects the addressed byte/half of a BRAM word and sign- or zero-extends it per funct3.
module riscv_load_align
  import riscv_constants::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'b0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Memory stage: issues BRAM accesses for RV32I loads/stores, passes ALU results through,
// and retires an aligned writeback result; stalls upstream while a load is in flight.
module riscv_lsu
  import riscv_constants::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         valid_in,
  input  mem_op_t      mem_op_in,
  input  logic [2:0]   funct3_in,
  input  logic [31:0]  addr_in,
  input  logic [31:0]  store_data_in,
  input  logic [4:0]   rd_in,
  output logic         busy_out,
  riscv_lsu_if.master  mem,
  output logic         wb_valid_out,
  output logic         wb_we_out,
  output logic [4:0]   wb_rd_out,
  output logic [31:0]  wb_data_out,
  output logic         misaligned_out
);

  lsu_state_t state_q, state_d;
  logic [2:0] cnt_q;
  logic [4:0] ld_rd_q;
  logic [2:0] ld_f3_q;
  logic [1:0] ld_off_q;

  logic        accept, fault, load_go, load_done;
  logic [31:0] load_data;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;

  logic                  mem_en_d, mem_en_q;
  logic [3:0]            mem_we_d, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_d, mem_addr_q;
  logic [31:0]           mem_wdata_d, mem_wdata_q;
  logic                  wb_valid_d, wb_valid_q;
  logic                  wb_we_d, wb_we_q;
  logic [4:0]            wb_rd_d, wb_rd_q;
  logic [31:0]           wb_data_d, wb_data_q;
  logic                  mis_d, mis_q;

  assign accept    = valid_in && (state_q == IDLE);
  assign fault     = access_fault(mem_op_in, funct3_in, addr_in[1:0]);
  assign load_go   = accept && (mem_op_in == MEM_LOAD) && !fault;
  assign load_done = (state_q == LOAD_WAIT) && (cnt_q == 3'd0);
  assign busy_out  = (state_q == LOAD_WAIT);

  riscv_load_align u_align (
    .rdata  (mem.mem_rdata_in),
    .off    (ld_off_q),
    .funct3 (ld_f3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (load_go) state_d = LOAD_WAIT;
      LOAD_WAIT: if (cnt_q == 3'd0) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The counter reaches zero in the cycle the BRAM data is valid, so that cycle samples it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q    <= 3'd0;
      ld_rd_q  <= 5'd0;
      ld_f3_q  <= 3'd0;
      ld_off_q <= 2'd0;
    end else if (load_go) begin
      cnt_q    <= 3'(READ_LATENCY);
      ld_rd_q  <= rd_in;
      ld_f3_q  <= funct3_in;
      ld_off_q <= addr_in[1:0];
    end else if (state_q == LOAD_WAIT && cnt_q != 3'd0) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  always_comb begin
    lane_we    = 4'b1111;
    lane_wdata = store_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        lane_we    = 4'b0001 << addr_in[1:0];
        lane_wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        lane_we    = 4'b0011 << addr_in[1:0];
        lane_wdata = {2{store_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    mis_d       = 1'b0;
    if (load_done) begin
      wb_valid_d = 1'b1;
      wb_we_d    = (ld_rd_q != 5'd0);
      wb_rd_d    = ld_rd_q;
      wb_data_d  = load_data;
    end else if (accept) begin
      if (mem_op_in == MEM_LOAD || mem_op_in == MEM_STORE) begin
        if (fault) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_in;
          wb_data_d  = 32'd0;
          mis_d      = 1'b1;
        end else if (mem_op_in == MEM_STORE) begin
          mem_en_d    = 1'b1;
          mem_we_d    = lane_we;
          mem_addr_d  = addr_in[ADDR_WIDTH+1:2];
          mem_wdata_d = lane_wdata;
          wb_valid_d  = 1'b1;
          wb_rd_d     = rd_in;
          wb_data_d   = 32'd0;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = addr_in[ADDR_WIDTH+1:2];
        end
      end else begin
        wb_valid_d = 1'b1;
        wb_we_d    = (rd_in != 5'd0);
        wb_rd_d    = rd_in;
        wb_data_d  = addr_in;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      mis_q       <= 1'b0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      mis_q       <= mis_d;
    end
  end

  assign mem.mem_en_out    = mem_en_q;
  assign mem.mem_we_out    = mem_we_q;
  assign mem.mem_addr_out  = mem_addr_q;
  assign mem.mem_wdata_out = mem_wdata_q;
  assign wb_valid_out      = wb_valid_q;
  assign wb_we_out         = wb_we_q;
  assign wb_rd_out         = wb_rd_q;
  assign wb_data_out       = wb_data_q;
  assign misaligned_out    = mis_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: table of single ops against a behavioural BRAM, a writeback
// scoreboard keyed by retire cycle, and hand-written back-to-back and reset sequences.
module tb_riscv_lsu;
  import riscv_constants::*;

  localparam int AW = 14;
  localparam int RL = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  mem_op_t     mem_op_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_in;
  logic        busy_out;
  logic        wb_valid_out;
  logic        wb_we_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;
  logic        misaligned_out;

  riscv_lsu_if #(.ADDR_WIDTH(AW)) bus ();

  riscv_lsu #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .mem_op_in      (mem_op_in),
    .funct3_in      (funct3_in),
    .addr_in        (addr_in),
    .store_data_in  (store_data_in),
    .rd_in          (rd_in),
    .busy_out       (busy_out),
    .mem            (bus),
    .wb_valid_out   (wb_valid_out),
    .wb_we_out      (wb_we_out),
    .wb_rd_out      (wb_rd_out),
    .wb_data_out    (wb_data_out),
    .misaligned_out (misaligned_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural BRAM: byte-enabled write, read data valid RL cycles after the enable.
  logic [31:0] mem_model [0:(1<<AW)-1];
  logic [31:0] rd_pipe [RL];

  always @(posedge clk_in) begin
    if (bus.mem_en_out) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we_out[b]) mem_model[bus.mem_addr_out][8*b +: 8] <= bus.mem_wdata_out[8*b +: 8];
      rd_pipe[0] <= mem_model[bus.mem_addr_out];
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata_in = rd_pipe[RL-1];

  typedef struct {
    mem_op_t     op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [13:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic        exp_wbwe;
    logic        exp_mis;
    logic        chk_data;
    logic [31:0] exp_data;
    int          lat;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    logic        chk_data;
    logic [31:0] data;
    int          cycle;
  } wb_exp_t;

  vec_t    vecs[$];
  wb_exp_t sb[$];
  int      cyc = 0;
  int      n_checks = 0;
  int      n_fail = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(mem_op_t op, logic [2:0] f3, logic [31:0] addr, logic [31:0] data,
                              logic [4:0] rd, logic en, logic [3:0] we, logic [13:0] maddr,
                              logic [31:0] wdata, logic wbwe, logic mis, logic chkd,
                              logic [31:0] expd, int lat);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.data = data; v.rd = rd;
    v.exp_en = en; v.exp_we = we; v.exp_maddr = maddr; v.exp_wdata = wdata;
    v.exp_wbwe = wbwe; v.exp_mis = mis; v.chk_data = chkd; v.exp_data = expd; v.lat = lat;
    return v;
  endfunction

  function automatic wb_exp_t mkexp(logic [4:0] rd, logic we, logic mis, logic chkd,
                                    logic [31:0] data, int cycle);
    wb_exp_t e;
    e.rd = rd; e.we = we; e.mis = mis; e.chk_data = chkd; e.data = data; e.cycle = cycle;
    return e;
  endfunction

  // Every retire must match the oldest outstanding expectation, including its cycle.
  always @(negedge clk_in) begin
    wb_exp_t e;
    if (!rst_in && wb_valid_out) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL wb_unexpected: got retire rd=%0d data=0x%08h, expected none", wb_rd_out, wb_data_out);
      end else begin
        e = sb.pop_front();
        check("wb_cycle", 32'(cyc), 32'(e.cycle));
        check("wb_rd", 32'(wb_rd_out), 32'(e.rd));
        check("wb_we", 32'(wb_we_out), 32'(e.we));
        check("misaligned", 32'(misaligned_out), 32'(e.mis));
        if (e.chk_data) check("wb_data", wb_data_out, e.data);
      end
    end
    if (!rst_in && misaligned_out && !wb_valid_out) check("mis_without_valid", 32'(misaligned_out), 32'd0);
  end

  task automatic applyStimulus(input vec_t v);
    @(posedge clk_in); #1;
    valid_in = 1'b1; mem_op_in = v.op; funct3_in = v.f3;
    addr_in = v.addr; store_data_in = v.data; rd_in = v.rd;
    sb.push_back(mkexp(v.rd, v.exp_wbwe, v.exp_mis, v.chk_data, v.exp_data, cyc + v.lat));
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v);
    @(negedge clk_in);
    check("mem_en", 32'(bus.mem_en_out), 32'(v.exp_en));
    check("mem_we", 32'(bus.mem_we_out), 32'(v.exp_we));
    if (v.exp_en) check("mem_addr", 32'(bus.mem_addr_out), 32'(v.exp_maddr));
    if (v.exp_en && v.op == MEM_STORE) check("mem_wdata", bus.mem_wdata_out, v.exp_wdata);
    check("busy_t1", 32'(busy_out), (v.lat > 1) ? 32'd1 : 32'd0);
    if (v.lat > 1) begin
      for (int k = 1; k <= RL; k++) begin
        @(negedge clk_in);
        check("busy_wait", 32'(busy_out), 32'd1);
        check("mem_en_pulse", 32'(bus.mem_en_out), 32'd0);
      end
    end
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk_in); #2;
    end
    check("retire_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  t0;
    bit  ok;

    vecs.push_back(mk(MEM_NONE,  F3_LB,  32'h0000_1234, 32'h0,          5'd5,  0, 4'b0000, 14'h0,    32'h0,          1, 0, 1, 32'h0000_1234, 1));
    vecs.push_back(mk(MEM_NONE,  F3_LB,  32'h0000_1234, 32'h0,          5'd0,  0, 4'b0000, 14'h0,    32'h0,          0, 0, 1, 32'h0000_1234, 1));
    vecs.push_back(mk(MEM_NONE,  3'b111, 32'hDEAD_BEEF, 32'h0,          5'd31, 0, 4'b0000, 14'h0,    32'h0,          1, 0, 1, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(MEM_STORE, F3_LB,  32'h0000_0102, 32'hAABB_CCDD, 5'd7,  1, 4'b0100, 14'h040,  32'hDDDD_DDDD, 0, 0, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_STORE, F3_LH,  32'h0000_0206, 32'h1122_3344, 5'd8,  1, 4'b1100, 14'h081,  32'h3344_3344, 0, 0, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_STORE, F3_LW,  32'h0000_0040, 32'h80FF_7F01, 5'd9,  1, 4'b1111, 14'h010,  32'h80FF_7F01, 0, 0, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_LOAD,  F3_LB,  32'h0000_0043, 32'h0,          5'd1,  1, 4'b0000, 14'h010,  32'h0,          1, 0, 1, 32'hFFFF_FF80, 2+RL));
    vecs.push_back(mk(MEM_LOAD,  F3_LBU, 32'h0000_0043, 32'h0,          5'd2,  1, 4'b0000, 14'h010,  32'h0,          1, 0, 1, 32'h0000_0080, 2+RL));
    vecs.push_back(mk(MEM_LOAD,  F3_LH,  32'h0000_0042, 32'h0,          5'd3,  1, 4'b0000, 14'h010,  32'h0,          1, 0, 1, 32'hFFFF_80FF, 2+RL));
    vecs.push_back(mk(MEM_LOAD,  F3_LHU, 32'h0000_0040, 32'h0,          5'd4,  1, 4'b0000, 14'h010,  32'h0,          1, 0, 1, 32'h0000_7F01, 2+RL));
    vecs.push_back(mk(MEM_LOAD,  F3_LW,  32'h0000_0040, 32'h0,          5'd5,  1, 4'b0000, 14'h010,  32'h0,          1, 0, 1, 32'h80FF_7F01, 2+RL));
    vecs.push_back(mk(MEM_LOAD,  F3_LW,  32'h0000_0040, 32'h0,          5'd0,  1, 4'b0000, 14'h010,  32'h0,          0, 0, 1, 32'h80FF_7F01, 2+RL));
    vecs.push_back(mk(MEM_LOAD,  F3_LW,  32'h0000_0006, 32'h0,          5'd6,  0, 4'b0000, 14'h0,    32'h0,          0, 1, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_LOAD,  F3_LH,  32'h0000_0041, 32'h0,          5'd6,  0, 4'b0000, 14'h0,    32'h0,          0, 1, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_STORE, F3_LH,  32'h0000_0043, 32'h1234_5678, 5'd0,  0, 4'b0000, 14'h0,    32'h0,          0, 1, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_LOAD,  3'b011, 32'h0000_0000, 32'h0,          5'd6,  0, 4'b0000, 14'h0,    32'h0,          0, 1, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_LOAD,  3'b110, 32'h0000_0000, 32'h0,          5'd6,  0, 4'b0000, 14'h0,    32'h0,          0, 1, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_STORE, F3_LBU, 32'h0000_0000, 32'h1234_5678, 5'd0,  0, 4'b0000, 14'h0,    32'h0,          0, 1, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_STORE, F3_LW,  32'hFFFF_0044, 32'h1234_5678, 5'd0,  1, 4'b1111, 14'h011,  32'h1234_5678, 0, 0, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_STORE, F3_LB,  32'h0000_0045, 32'h0000_00A5, 5'd0,  1, 4'b0010, 14'h011,  32'hA5A5_A5A5, 0, 0, 0, 32'h0,          1));
    vecs.push_back(mk(MEM_LOAD,  F3_LW,  32'h0000_0044, 32'h0,          5'd12, 1, 4'b0000, 14'h011,  32'h0,          1, 0, 1, 32'h1234_A578, 2+RL));
    vecs.push_back(mk(MEM_LOAD,  F3_LB,  32'h0000_0045, 32'h0,          5'd13, 1, 4'b0000, 14'h011,  32'h0,          1, 0, 1, 32'hFFFF_FFA5, 2+RL));
    vecs.push_back(mk(MEM_LOAD,  F3_LHU, 32'hFFFF_0046, 32'h0,          5'd14, 1, 4'b0000, 14'h011,  32'h0,          1, 0, 1, 32'h0000_1234, 2+RL));

    for (int i = 0; i < (1 << AW); i++) mem_model[i] = 32'h0;
    rst_in = 1'b1; valid_in = 1'b0; mem_op_in = MEM_NONE; funct3_in = 3'd0;
    addr_in = 32'd0; store_data_in = 32'd0; rd_in = 5'd0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_wb_valid", 32'(wb_valid_out), 32'd0);
    check("reset_mem_en", 32'(bus.mem_en_out), 32'd0);
    check("reset_wb_data", wb_data_out, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
      waitDrain();
      check("busy_after", 32'(busy_out), 32'd0);
    end

    // Store then load on consecutive cycles, with a third op held high through the busy window.
    @(posedge clk_in); #1;
    t0 = cyc;
    valid_in = 1'b1; mem_op_in = MEM_STORE; funct3_in = F3_LW;
    addr_in = 32'h0000_0080; store_data_in = 32'hCAFE_F00D; rd_in = 5'd9;
    sb.push_back(mkexp(5'd9, 1'b0, 1'b0, 1'b0, 32'h0, t0 + 1));
    @(posedge clk_in); #1;
    mem_op_in = MEM_LOAD; funct3_in = F3_LW; addr_in = 32'h0000_0080; rd_in = 5'd10;
    sb.push_back(mkexp(5'd10, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, t0 + 1 + 2 + RL));
    @(posedge clk_in); #1;
    mem_op_in = MEM_NONE; funct3_in = F3_LB; addr_in = 32'h0000_5555; rd_in = 5'd11;
    sb.push_back(mkexp(5'd11, 1'b1, 1'b0, 1'b1, 32'h0000_5555, t0 + 1 + 2 + RL + 1));
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (!busy_out) begin
        ok = 1'b1;
        break;
      end
    end
    check("held_op_released", 32'(ok), 32'd1);
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    waitDrain();

    // Reset pulsed two cycles into a load: the load must vanish and the unit restart cleanly.
    @(posedge clk_in); #1;
    valid_in = 1'b1; mem_op_in = MEM_LOAD; funct3_in = F3_LW; addr_in = 32'h0000_0040; rd_in = 5'd15;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en_out), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we_out), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr_out), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata_out, 32'd0);
    check("rst_wb_valid", 32'(wb_valid_out), 32'd0);
    check("rst_wb_we", 32'(wb_we_out), 32'd0);
    check("rst_wb_rd", 32'(wb_rd_out), 32'd0);
    check("rst_wb_data", wb_data_out, 32'd0);
    check("rst_misaligned", 32'(misaligned_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    valid_in = 1'b1; mem_op_in = MEM_NONE; funct3_in = F3_LB; addr_in = 32'h0000_0077; rd_in = 5'd3;
    sb.push_back(mkexp(5'd3, 1'b1, 1'b0, 1'b1, 32'h0000_0077, cyc + 1));
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    waitDrain();
    repeat (8) @(posedge clk_in);
    #2;
    check("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
